// File: rtl/shift_pipeline_elastic_pkg.sv
// shift_pipeline_elastic_pkg
// Shared types and helpers for the elastic shift pipeline.
//   mode_e        : entry transform selector carried with each beat
//   DEF_XOR_KEY   : default XOR key (8 bits, zero-extended to WIDTH by users)
//   DEF_AND_MASK  : default AND mask (8 bits, zero-extended to WIDTH by users)
//   XFORM_MAX_W   : widest data path the transform helper supports
//   xform()       : bitwise entry transform
package shift_pipeline_elastic_pkg;

   typedef enum logic [1:0] {
      MODE_PASS    = 2'b00,
      MODE_XOR     = 2'b01,
      MODE_AND     = 2'b10,
      MODE_XOR_AND = 2'b11
   } mode_e;

   localparam logic [7:0] DEF_XOR_KEY  = 8'hAA;
   localparam logic [7:0] DEF_AND_MASK = 8'hF0;

   // Package functions cannot take a width parameter, so the transform runs
   // on a fixed wide vector and callers size in and out with casts.
   localparam int XFORM_MAX_W = 64;

   function automatic logic [XFORM_MAX_W-1:0] xform(
      input logic [XFORM_MAX_W-1:0] d,
      input mode_e                  m,
      input logic [XFORM_MAX_W-1:0] key,
      input logic [XFORM_MAX_W-1:0] mask
   );
      logic [XFORM_MAX_W-1:0] r;
      case (m)
         MODE_XOR:     r = d ^ key;
         MODE_AND:     r = d & mask;
         MODE_XOR_AND: r = (d ^ key) & mask;
         default:      r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/shift_pipeline_elastic_if.sv
// shift_pipeline_elastic_if
// Streaming bus around the elastic pipeline: upstream valid/ready/mode/data,
// downstream valid/ready/data and the occupancy count.
//   master : source + consumer side (drives in_valid, mode, data_in, out_ready)
//   slave  : the pipeline (drives in_ready, out_valid, data_out, count)
interface shift_pipeline_elastic_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [1:0]       mode;
   logic [WIDTH-1:0] data_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    count;

   modport master (
      output in_valid, mode, data_in, out_ready,
      input  in_ready, out_valid, data_out, count
   );

   modport slave (
      input  in_valid, mode, data_in, out_ready,
      output in_ready, out_valid, data_out, count
   );
endinterface

// File: rtl/shift_pipeline_elastic_stage.sv
// pipe_stage_elastic
// One valid/data register stage with an upstream/downstream handshake.
//   clk, reset, flush : clock, sync active-high reset, sync clear
//   up_valid/up_data  : beat offered by the previous stage (or entry)
//   up_ready          : this stage loads on this edge
//   dn_valid/dn_data  : registered beat held by this stage
//   dn_ready          : next stage (or consumer) takes the beat
module pipe_stage_elastic
   import shift_pipeline_elastic_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   output logic             up_ready,
   output logic             dn_valid,
   output logic [WIDTH-1:0] dn_data,
   input  logic             dn_ready
);

   logic             vld_q;
   logic [WIDTH-1:0] dat_q;

   // Load when empty or when the held beat leaves this edge; an empty stage
   // in front collapses as a bubble.
   assign up_ready = !vld_q || dn_ready;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else if (up_ready) begin
         vld_q <= up_valid;
         // Data only moves with a real beat so an empty pipe keeps showing
         // the last delivered value.
         if (up_valid)
            dat_q <= up_data;
      end
   end

   assign dn_valid = vld_q;
   assign dn_data  = dat_q;

endmodule

// File: rtl/shift_pipeline_elastic.sv
// shift_pipeline_elastic
// Entry transform (pass / XOR key / AND mask / XOR then AND) followed by
// DEPTH elastic register stages with valid/ready on both sides.
//   clk   : clock
//   reset : sync active-high reset, clears every stage and the count
//   flush : sync clear of all in-flight beats (lower priority than reset)
//   bus   : slave side of shift_pipeline_elastic_if (in/out handshakes,
//           mode, data, count)
// WIDTH must not exceed XFORM_MAX_W.
module shift_pipeline_elastic
   import shift_pipeline_elastic_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] XOR_KEY  = WIDTH'(DEF_XOR_KEY),
   parameter logic [WIDTH-1:0] AND_MASK = WIDTH'(DEF_AND_MASK)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   shift_pipeline_elastic_if.slave  bus
);

   localparam int CW = $clog2(DEPTH + 1);

   // Element i is the link into stage i; element DEPTH is the output side.
   logic             lv [DEPTH+1];
   logic [WIDTH-1:0] ld [DEPTH+1];
   logic             lr [DEPTH+1];

   logic             acc;
   logic             dlv;
   logic [WIDTH-1:0] xd;
   logic [CW-1:0]    cnt_q;

   assign xd = WIDTH'(xform(XFORM_MAX_W'(bus.data_in), mode_e'(bus.mode),
                            XFORM_MAX_W'(XOR_KEY), XFORM_MAX_W'(AND_MASK)));

   // Ready ripples back combinationally from out_ready so a full pipe can
   // accept and deliver on the same edge.
   assign bus.in_ready = lr[0] && !reset && !flush;
   assign acc          = bus.in_valid && bus.in_ready;
   assign dlv          = lv[DEPTH] && bus.out_ready;

   assign lv[0]     = acc;
   assign ld[0]     = xd;
   assign lr[DEPTH] = bus.out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      pipe_stage_elastic #(.WIDTH(WIDTH)) u_stage (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush),
         .up_valid (lv[i]),
         .up_data  (ld[i]),
         .up_ready (lr[i]),
         .dn_valid (lv[i+1]),
         .dn_data  (ld[i+1]),
         .dn_ready (lr[i+1])
      );
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         cnt_q <= '0;
      end else begin
         case ({acc, dlv})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign bus.out_valid = lv[DEPTH];
   assign bus.data_out  = ld[DEPTH];
   assign bus.count     = cnt_q;

endmodule

// File: doc/shift_pipeline_elastic.md
# shift_pipeline_elastic

Parametrised successor to the fixed four-stage transform shift pipeline. It applies a per-beat selectable XOR-key / mask transform at entry, then carries each beat through `DEPTH` register stages with per-stage valid bits and a valid/ready handshake on both sides, so back-pressure stalls the chain without losing data. It sits between a streaming byte source and a downstream consumer that may stall, and also supports a synchronous flush.

## Interface
- `WIDTH`, 8: data width in bits (≥1).
- `DEPTH`, 4: number of register stages (≥1).
- `XOR_KEY`, 'hAA (WIDTH bits): XOR key.
- `AND_MASK`, 'hF0 (WIDTH bits): AND mask.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `flush`  in  1  synchronous clear of all in-flight beats.
- `in_valid`  in  1  source presents a beat.
- `in_ready`  out  1  block accepts the beat this cycle.
- `mode`  in  2  transform, sampled with the beat: 00 pass, 01 XOR, 10 AND, 11 XOR then AND.
- `data_in`  in  WIDTH  input beat.
- `out_valid`  out  1  `data_out` holds a valid beat.
- `out_ready`  in  1  consumer takes the beat.
- `data_out`  out  WIDTH  last-stage data.
- `count`  out  $clog2(DEPTH+1)  number of valid stages.

## Operation
- Transform at entry:
  - 00: d.
  - 01: d ^ XOR_KEY.
  - 10: d & AND_MASK.
  - 11: (d ^ XOR_KEY) & AND_MASK.
  - Purely bitwise; no width growth.
- Stage i holds {valid_i, data_i}. Stage 0 is the entry; stage DEPTH-1 drives `data_out` / `out_valid`.
- Advance rule:
  - Last stage frees when `out_valid && out_ready`.
  - Stage i loads from stage i-1 when stage i is empty or freeing. Bubbles collapse.
- `in_ready` = stage 0 empty or stage 0 advancing, and neither `reset` nor `flush` is high. It is combinational from `out_ready` and the valid bits.
- Accept = `in_valid && in_ready`. The transformed beat loads into stage 0.
- Beats leave in acceptance order. No beat is duplicated or dropped except by flush or reset.
- `count` tracks occupied stages.
  - +1 on accept, −1 on output handshake.
  - Both on the same edge leaves `count` unchanged.
- Priority: `reset` > `flush` > normal operation.
  - `flush` clears all valid bits and data to 0 on that edge.
  - A beat presented in the flush cycle is not accepted.
  - An output handshake in the flush cycle still counts as delivered.
- Reset values:
  - All valid bits 0, all data 0.
  - `out_valid` 0, `data_out` 0, `count` 0.
  - `in_ready` is 0 while `reset` is high and 1 in the first cycle after.
- Reset or flush mid-stream discards all in-flight beats. No partial state remains.

## Timing
- Latency: a beat accepted in cycle 0 appears with `out_valid` high in cycle DEPTH when `out_ready` has stayed high. DEPTH=4 gives 4 cycles.
- Throughput: one beat per cycle when `out_ready` is held high. A full pipe with `out_ready` high accepts and delivers on the same edge.
- Full: `count`==DEPTH and `out_ready` low force `in_ready` low in the same cycle.
- Empty: `out_valid` is low. `data_out` holds the last delivered value (0 after reset or flush).
- `out_valid` / `data_out` are registered. `in_ready` is combinational.
- `data_out` is stable while `out_valid && !out_ready`.

## Structure
- Shared package holds:
  - The mode enum (`MODE_PASS`, `MODE_XOR`, `MODE_AND`, `MODE_XOR_AND`).
  - Default key and mask constants 'hAA / 'hF0.
- One sub-module, `pipe_stage_elastic`: a single valid/data stage with upstream/downstream handshake and flush. It is instantiated DEPTH times in a generate loop.
- Transform logic is a package function used at entry.

## Test plan
- Modes, default parameters, `out_ready`=1:
  - 0x5A mode 11 → 0xF0.
  - 0x0F mode 11 → 0xA0.
  - 0x0F mode 01 → 0xA5.
  - 0x3C mode 10 → 0x30.
  - 0x3C mode 00 → 0x3C.
  - Each emerges 4 cycles after accept, in order.
- Back-pressure, `out_ready`=0, stream 0x01..0x06 mode 00:
  - Four beats accepted, then `in_ready`=0 and `count`=4.
  - Release `out_ready`: 0x01..0x06 delivered in order, one per cycle, no loss.
- Full throughput: full pipe, `in_valid`=`out_ready`=1 for 10 cycles.
  - One accept and one delivery per cycle.
  - `count` holds 4.
- Bubbles: `in_valid` toggles every cycle with random `out_ready`.
  - Output order matches the scoreboard.
  - `count` equals accepts − deliveries.
- Flush with 3 beats in flight while `in_valid`=1:
  - Next cycle `count`=0, `out_valid`=0, `data_out`=0.
  - The presented beat is not accepted.
- Reset mid-stream, DEPTH=6 / WIDTH=16 instance, asserted for 1 cycle:
  - All outputs take reset values.
  - A beat accepted in the first cycle after reset emerges 6 cycles later.
